// File: rtl/usr_pkg.sv
// Shared types for the universal shift-register controller: FSM states and
// the 2-bit register mode encoding driven from the controller into usr_core.
package usr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_LOAD  = 2'b01,
    ST_SHIFT = 2'b10,
    ST_DONE  = 2'b11
  } state_t;

  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_SHR  = 2'b01,
    MODE_SHL  = 2'b10,
    MODE_LOAD = 2'b11
  } mode_t;

  // dir = 1 selects a left shift, dir = 0 a right shift.
  function automatic mode_t shift_mode(input logic dir);
    return dir ? MODE_SHL : MODE_SHR;
  endfunction

endpackage

// File: rtl/usr_ctrl_if.sv
// Request/status bundle of usr_ctrl: the requester drives the master side,
// the controller implements the slave side.
interface usr_ctrl_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
);

  logic             start;
  logic             dir;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] data_in;
  logic             ser_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] data_out;
  logic             ser_out;

  modport master (
    output start, dir, count, data_in, ser_in,
    input  busy, done, data_out, ser_out
  );

  modport slave (
    input  start, dir, count, data_in, ser_in,
    output busy, done, data_out, ser_out
  );

endinterface

// File: rtl/usr_core.sv
// WIDTH-bit universal register: hold, shift right, shift left or parallel load.
// Build option USR_CTRL_ROTATE_EN turns the shifts into rotates (ser_in unused).
module usr_core
  import usr_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  mode_t            mode,
  input  logic [WIDTH-1:0] d,
  input  logic             ser_in,
  output logic [WIDTH-1:0] q
);

  logic fill_r;
  logic fill_l;

`ifdef USR_CTRL_ROTATE_EN
  // Rotation recirculates the bit leaving the register; the serial input is dropped.
  logic unused_ser_in;
  assign unused_ser_in = ser_in;
  assign fill_r        = q[0];
  assign fill_l        = q[WIDTH-1];
`else
  assign fill_r = ser_in;
  assign fill_l = ser_in;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else begin
      case (mode)
        MODE_SHR:  q <= {fill_r, q[WIDTH-1:1]};
        MODE_SHL:  q <= {q[WIDTH-2:0], fill_l};
        MODE_LOAD: q <= d;
        default:   q <= q;
      endcase
    end
  end

endmodule

// File: rtl/usr_ctrl.sv
// Controller that loads a universal shift register and shifts it count times.
// Optional build macro: USR_CTRL_ROTATE_EN (rotate instead of serial fill).
module usr_ctrl
  import usr_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic     clk,
  input  logic     rst,
  usr_ctrl_if.slave bus
);

  state_t           state;
  state_t           state_nxt;
  mode_t            mode;
  logic             dir_lat;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] data_lat;
  logic [WIDTH-1:0] q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Operands are captured only on an accepted start, so changes while busy are invisible.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dir_lat  <= 1'b0;
      cnt      <= '0;
      data_lat <= '0;
    end else if (state == ST_IDLE && bus.start) begin
      dir_lat  <= bus.dir;
      cnt      <= bus.count;
      data_lat <= bus.data_in;
    end else if (state == ST_SHIFT) begin
      cnt <= cnt - 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    mode      = MODE_HOLD;
    case (state)
      ST_IDLE: begin
        if (bus.start) state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        mode      = MODE_LOAD;
        state_nxt = (cnt != '0) ? ST_SHIFT : ST_DONE;
      end
      ST_SHIFT: begin
        mode = shift_mode(dir_lat);
        // cnt still holds the remaining shifts including the one happening now.
        if (cnt == CNT_W'(1)) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  usr_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .clk    (clk),
    .rst    (rst),
    .mode   (mode),
    .d      (data_lat),
    .ser_in (bus.ser_in),
    .q      (q)
  );

  assign bus.busy     = (state != ST_IDLE);
  assign bus.done     = (state == ST_DONE);
  assign bus.data_out = q;
  assign bus.ser_out  = dir_lat ? q[WIDTH-1] : q[0];

endmodule

// File: tb/tb_usr_ctrl.sv
// Directed bench for usr_ctrl (WIDTH=4, CNT_W=3) with a per-cycle scoreboard
// of expected data_out/busy/done/ser_out built from a reference model.
module tb_usr_ctrl;

  localparam int WIDTH = 4;
  localparam int CNT_W = 3;

`ifdef USR_CTRL_ROTATE_EN
  localparam bit ROT = 1'b1;
`else
  localparam bit ROT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  usr_ctrl_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  usr_ctrl #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [3:0] data;
    logic       busy;
    logic       done;
    logic       ser;
  } exp_t;

  exp_t       sb[$];
  int         checks = 0;
  int         errors = 0;
  logic [3:0] mq;
  logic       mdir;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] mshift(input logic [3:0] v, input logic d, input logic s);
    logic f;
    f = s;
    if (ROT) f = d ? v[3] : v[0];
    return d ? {v[2:0], f} : {f, v[3:1]};
  endfunction

  function automatic void push(input logic b, input logic dn);
    exp_t e;
    e.data = mq;
    e.busy = b;
    e.done = dn;
    e.ser  = mdir ? mq[3] : mq[0];
    sb.push_back(e);
  endfunction

  // Called at a falling edge; returns at a falling edge with the DUT back in IDLE.
  task automatic run_op(input logic [3:0] d, input logic dr, input logic [2:0] c,
                        input logic s, input bit poke, input bit tog, input string tag);
    exp_t e;
    int   k;
    bus.start   = 1'b1;
    bus.data_in = d;
    bus.dir     = dr;
    bus.count   = c;
    bus.ser_in  = s;
    mdir = dr;
    push(1'b1, 1'b0);
    mq = d;
    push(1'b1, c == 3'd0);
    for (int i = 1; i <= int'(c); i++) begin
      mq = mshift(mq, dr, s);
      push(1'b1, i == int'(c));
    end
    push(1'b0, 1'b0);
    k = 0;
    while (sb.size() > 0) begin
      @(posedge clk);
      #1;
      e = sb.pop_front();
      chk($sformatf("%s.data[%0d]", tag, k), 32'(bus.data_out), 32'(e.data));
      chk($sformatf("%s.busy[%0d]", tag, k), 32'(bus.busy), 32'(e.busy));
      chk($sformatf("%s.done[%0d]", tag, k), 32'(bus.done), 32'(e.done));
      chk($sformatf("%s.ser_out[%0d]", tag, k), 32'(bus.ser_out), 32'(e.ser));
      @(negedge clk);
      if (k == 0) bus.start = 1'b0;
      if (poke && k == 1) begin
        bus.start   = 1'b1;
        bus.data_in = 4'hF;
        bus.dir     = ~dr;
        bus.count   = 3'd7;
      end
      if (poke && k == 2) bus.start = 1'b0;
      if (tog) bus.ser_in = ~bus.ser_in;
      k++;
    end
  endtask

  initial begin
    rst         = 1'b1;
    bus.start   = 1'b0;
    bus.dir     = 1'b0;
    bus.count   = '0;
    bus.data_in = '0;
    bus.ser_in  = 1'b0;
    mq          = 4'h0;
    mdir        = 1'b0;
    #1;
    chk("reset.data", 32'(bus.data_out), 32'h0);
    chk("reset.busy", 32'(bus.busy), 32'h0);
    chk("reset.done", 32'(bus.done), 32'h0);
    chk("reset.ser_out", 32'(bus.ser_out), 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    run_op(4'b1011, 1'b0, 3'd2, 1'b0, 1'b0, 1'b0, "shr2");
    run_op(4'b0001, 1'b1, 3'd3, 1'b1, 1'b0, 1'b0, "shl3");
    run_op(4'b0110, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, "cnt0");
    run_op(4'b1100, 1'b0, 3'd2, 1'b1, 1'b1, 1'b0, "busy_start");
    run_op(4'b0011, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0, "next_accept");
    run_op(4'b1010, 1'b1, 3'd6, 1'b0, 1'b0, 1'b0, "cnt_gt_width");

    // Abort an operation in the middle of SHIFT, between clock edges.
    bus.start   = 1'b1;
    bus.data_in = 4'b1011;
    bus.dir     = 1'b1;
    bus.count   = 3'd5;
    bus.ser_in  = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("abort.data", 32'(bus.data_out), 32'h0);
    chk("abort.busy", 32'(bus.busy), 32'h0);
    chk("abort.done", 32'(bus.done), 32'h0);
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("abort.hold_done", 32'(bus.done), 32'h0);
    end
    @(negedge clk);
    rst  = 1'b0;
    mq   = 4'h0;
    mdir = 1'b0;
    @(negedge clk);
    run_op(4'b0101, 1'b0, 3'd1, 1'b1, 1'b0, 1'b0, "after_abort");

    run_op(4'b1000, 1'b0, 3'd4, 1'b0, 1'b0, ROT, "rot4");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
